fib_bcd_display: RTL and testbench
==================================

// Module: fib_bcd_display
// PURPOSE
//  Downstream consumer of the fibonacci generator's value bus. Converts a sampled
//  binary value to BCD with a serial double-dabble engine (one bit per clock) and
//  shows it on a multiplexed, common-anode 7-segment display. Leading zeros are blanked.
//  Sits beside fibonacci in the fpga top, on the divided clock domain.
// PARAMETERS
//  WIDTH     8     binary width of value; matches fibonacci WIDTH
//  DIGITS    3     display digits; must satisfy 10**DIGITS > 2**WIDTH-1 (elaboration check)
//  SCAN_DIV  1024  clocks each digit stays lit; must be >= 2
// PORTS
//  clk      in   1                 single clock; all logic on rising edge
//  reset    in   1                 synchronous, active-high
//  value    in   WIDTH             binary value from fibonacci
//  sample   in   1                 1-cycle strobe: capture value and start conversion
//  busy     out  1                 conversion in progress
//  done     out  1                 1-cycle pulse: new result committed to display
//  seg      out  7                 segments {g,f,e,d,c,b,a}, active-low
//  an       out  DIGITS            digit enables, active-low, one-hot-low when lit
// BEHAVIOUR
//  Reset: busy=0, done=0, seg=7'h7F, an=all 1s, display reg=0, scan counters=0,
//   FSM=IDLE. Reset mid-conversion aborts it; partial result is discarded.
//  FSM IDLE -> SHIFT -> COMMIT -> IDLE.
//   IDLE: on sample=1, shift_reg<=value, bcd<=0, bitcnt<=WIDTH, busy<=1 -> SHIFT.
//   SHIFT (WIDTH cycles): per cycle, first add 3 to every BCD nibble >=5, then shift
//    {bcd,shift_reg} left 1. bitcnt decrements; on the last shift -> COMMIT.
//   COMMIT (1 cycle): display reg<=bcd, done=1, busy=0 -> IDLE.
//  Latency: sample at edge t -> done high in cycle t+WIDTH+1. The display updates
//   on the same edge that raises done.
//  sample while busy: ignored, with no queueing. sample in the COMMIT cycle: ignored.
//  value is sampled only in IDLE with sample=1. Changes at other times have no effect.
//  The display reg holds the previous result throughout a conversion.
//  Scanner: free-running prescaler 0..SCAN_DIV-1. At wrap, digit index advances
//   0..DIGITS-1 and then wraps to 0. Digit 0 is least significant.
//   an[idx]=0 and all other an bits=1 while the digit is lit. seg=decode(display[idx]).
//  Blanking: a digit above the most-significant nonzero digit drives seg=7'h7F.
//   Its an bit still cycles. Digit 0 is never blanked, so 0 displays as "0".
//  Nibble values 10..15 cannot occur; the decoder maps them to blank.
//  Prescaler and index run independently of the FSM, including during a conversion.
// STRUCTURE
//  Shared include fib_defs.vh: the FSM state encodings (IDLE/SHIFT/COMMIT) and
//   the 7-seg patterns SEG_0..SEG_9 and SEG_BLANK (active-low).
//  Sub-module bcd_to_seg7: combinational 4-bit nibble -> 7-bit pattern, blanks
//   on input >9 or blank=1.
//  Top level: FSM + double-dabble datapath, display reg, scan prescaler/index,
//   blanking mask.
// TESTING (WIDTH=8, DIGITS=3, SCAN_DIV=4 unless noted)
//  1. reset held 3 cycles -> busy=0, done=0, an=3'b111, seg=7'h7F. After release,
//     digit 0 shows SEG_0 and digits 1 and 2 are blank.
//  2. value=8'd233, sample pulse -> busy for 8 cycles, done 9 cycles after the
//     sample edge, display=2/3/3. Scan order: an=110 seg=SEG_3, an=101 SEG_3,
//     an=011 SEG_2.
//  3. value=8'd255 -> 2/5/5. value=8'd5 -> digit0=SEG_5, digits 1 and 2 blank.
//     value=8'd0 -> digit0=SEG_0.
//  4. sample=1 again 3 cycles after a sample with value changed -> the second strobe
//     is ignored, the first value is displayed, and exactly one done pulse occurs.
//  5. reset asserted 4 cycles into a conversion -> busy=0, no done pulse, display=0.
//     A following sample of 8'd89 displays 089 with the leading zero blanked.
//  6. WIDTH=32, DIGITS=10, value=32'd2971215073, sample -> done after 33 cycles and
//     all ten digits match the decimal string.

Source files
------------

// File: rtl/fib_bcd_display_pkg.sv
// Shared definitions for the Fibonacci BCD display: FSM encoding, active-low
// 7-segment patterns {g,f,e,d,c,b,a}, and the parameter sanity check.
package fib_bcd_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // True when DIGITS decimal digits can hold any WIDTH-bit value and the
  // scan divider is usable. Wide arithmetic so WIDTH=32/DIGITS=10 still fits.
  function automatic bit params_ok(input int width, input int digits,
                                   input int scan_div);
    logic [127:0] pow10;
    logic [127:0] max_val;
    pow10 = 128'd1;
    for (int i = 0; i < digits; i++) pow10 = pow10 * 128'd10;
    max_val = (128'd1 << width) - 128'd1;
    return (pow10 > max_val) && (scan_div >= 2);
  endfunction

endpackage

// File: rtl/fib_bcd_display_bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder. Values above 9
// and an explicit blank request both produce an all-off pattern.
module bcd_to_seg7
  import fib_bcd_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  // Decode one digit; blank wins over the nibble value.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    seg = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/fib_bcd_display.sv
// Captures a binary value, converts it to BCD with a serial double-dabble
// engine (one bit per clock) and drives a multiplexed common-anode display
// with leading-zero blanking. The scanner runs independently of conversions.
module fib_bcd_display
  import fib_bcd_display_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  value,
  input  logic              sample,
  output logic              busy,
  output logic              done,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (!params_ok(WIDTH, DIGITS, SCAN_DIV)) begin : g_bad_params
    $error("fib_bcd_display: DIGITS too small for WIDTH, or SCAN_DIV < 2");
  end

  state_t                  state;
  logic [WIDTH-1:0]        shift_reg;
  logic [DIGITS-1:0][3:0]  bcd;
  logic [DIGITS-1:0][3:0]  bcd_adj;
  logic [DIGITS-1:0][3:0]  display;
  logic [CNT_W-1:0]        bitcnt;
  logic [PRE_W-1:0]        presc;
  logic [IDX_W-1:0]        idx;
  logic [DIGITS-1:0]       blank_mask;
  logic                    nz_above;
  logic [6:0]              seg_next;

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    // NOTE: combinational logic uses blocking '='; clocked state below uses non-blocking '<='.
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[i] >= 4'd5) bcd_adj[i] = bcd[i] + 4'd3;
    end
  end

  // Conversion FSM: capture in IDLE, WIDTH shifts, then commit to the display.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: display is a plain register (not a memory), so it is reset to show "0".
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      shift_reg <= '0;
      bcd       <= '0;
      bitcnt    <= '0;
      display   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sample) begin
            shift_reg <= value;
            bcd       <= '0;
            bitcnt    <= CNT_W'(WIDTH);
            busy      <= 1'b1;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {bcd, shift_reg} <= {bcd_adj, shift_reg} << 1;
          bitcnt           <= bitcnt - 1'b1;
          if (bitcnt == CNT_W'(1)) begin
            busy  <= 1'b0;
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          display <= bcd;
          done    <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Free-running prescaler; each wrap advances the lit digit, LSD first.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRE_W'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Blank every digit above the most-significant nonzero one; digit 0 never blanks.
  always_comb begin
    blank_mask = '0;
    nz_above   = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      nz_above      = nz_above | (display[i] != 4'd0);
      blank_mask[i] = ~nz_above;
    end
  end

  bcd_to_seg7 u_seg7 (
    .nibble (display[idx]),
    .blank  (blank_mask[idx]),
    .seg    (seg_next)
  );

  // Registered display drive: one anode low for the current digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(DIGITS'(1) << idx);
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_fib_bcd_display.sv
// Directed bench for fib_bcd_display: an 8-bit/3-digit instance for the main
// scenarios and a 32-bit/10-digit instance for the wide conversion.
module tb_fib_bcd_display;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30,
                         S4 = 7'h19, S5 = 7'h12, S6 = 7'h02, S7 = 7'h78,
                         S8 = 7'h00, S9 = 7'h10, SB = 7'h7F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  value8 = '0;
  logic        sample8 = 1'b0;
  logic        busy8, done8;
  logic [6:0]  seg8;
  logic [2:0]  an8;
  logic [31:0] value32 = '0;
  logic        sample32 = 1'b0;
  logic        busy32, done32;
  logic [6:0]  seg32;
  logic [9:0]  an32;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  fib_bcd_display #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4)) dut8 (
    .clk(clk), .reset(reset), .value(value8), .sample(sample8),
    .busy(busy8), .done(done8), .seg(seg8), .an(an8)
  );

  fib_bcd_display #(.WIDTH(32), .DIGITS(10), .SCAN_DIV(4)) dut32 (
    .clk(clk), .reset(reset), .value(value32), .sample(sample32),
    .busy(busy32), .done(done32), .seg(seg32), .an(an32)
  );

  function automatic logic [6:0] seg_of(input int n);
    case (n)
      0: return S0; 1: return S1; 2: return S2; 3: return S3; 4: return S4;
      5: return S5; 6: return S6; 7: return S7; 8: return S8; 9: return S9;
      default: return SB;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Wait (bounded) until digit d is lit on the chosen instance, then check its pattern.
  task automatic check_digit(input int inst, input int d, input logic [6:0] exp, input string tag);
    logic [9:0] want;
    bit         lit;
    int         k;
    want = ~(10'd1 << d);
    k    = 0;
    @(negedge clk);
    lit = (inst == 0) ? (an8 === want[2:0]) : (an32 === want);
    while (!lit && k < 200) begin
      @(negedge clk);
      k++;
      lit = (inst == 0) ? (an8 === want[2:0]) : (an32 === want);
    end
    chk({tag, " lit"}, 64'(lit), 64'd1);
    if (lit) chk(tag, 64'((inst == 0) ? seg8 : seg32), 64'(exp));
  endtask

  // One 8-bit conversion with latency checks: busy 8 cycles, done on the 9th edge.
  task automatic conv8(input logic [7:0] v, input string tag);
    @(negedge clk);
    value8  = v;
    sample8 = 1'b1;
    @(negedge clk);
    sample8 = 1'b0;
    chk({tag, " busy@t"}, 64'(busy8), 64'd1);
    repeat (7) @(negedge clk);
    chk({tag, " busy@t+7"}, 64'(busy8), 64'd1);
    chk({tag, " done@t+7"}, 64'(done8), 64'd0);
    @(negedge clk);
    chk({tag, " busy@t+8"}, 64'(busy8), 64'd0);
    chk({tag, " done@t+8"}, 64'(done8), 64'd0);
    @(negedge clk);
    chk({tag, " done@t+9"}, 64'(done8), 64'd1);
    @(negedge clk);
    chk({tag, " done@t+10"}, 64'(done8), 64'd0);
  endtask

  initial begin
    int dcnt;
    int k;
    int dig32 [10];

    // 1. reset state
    repeat (3) @(negedge clk);
    chk("rst busy", 64'(busy8), 64'd0);
    chk("rst done", 64'(done8), 64'd0);
    chk("rst an", 64'(an8), 64'h7);
    chk("rst seg", 64'(seg8), 64'h7F);
    chk("rst an32", 64'(an32), 64'h3FF);
    reset = 1'b0;
    check_digit(0, 0, S0, "rst d0");
    check_digit(0, 1, SB, "rst d1");
    check_digit(0, 2, SB, "rst d2");

    // 2. 233
    conv8(8'd233, "v233");
    check_digit(0, 0, S3, "v233 d0");
    check_digit(0, 1, S3, "v233 d1");
    check_digit(0, 2, S2, "v233 d2");

    // 3. 255, 5, 0
    conv8(8'd255, "v255");
    check_digit(0, 0, S5, "v255 d0");
    check_digit(0, 1, S5, "v255 d1");
    check_digit(0, 2, S2, "v255 d2");
    conv8(8'd5, "v5");
    check_digit(0, 0, S5, "v5 d0");
    check_digit(0, 1, SB, "v5 d1");
    check_digit(0, 2, SB, "v5 d2");
    conv8(8'd0, "v0");
    check_digit(0, 0, S0, "v0 d0");
    check_digit(0, 1, SB, "v0 d1");

    // 4. second strobe while busy is ignored
    @(negedge clk);
    value8  = 8'd100;
    sample8 = 1'b1;
    @(negedge clk);
    sample8 = 1'b0;
    dcnt    = int'(done8);
    repeat (2) begin
      @(negedge clk);
      dcnt += int'(done8);
    end
    value8  = 8'd200;
    sample8 = 1'b1;
    @(negedge clk);
    sample8 = 1'b0;
    dcnt += int'(done8);
    repeat (20) begin
      @(negedge clk);
      dcnt += int'(done8);
    end
    chk("busy strobe done count", 64'(dcnt), 64'd1);
    check_digit(0, 0, S0, "v100 d0");
    check_digit(0, 1, S0, "v100 d1");
    check_digit(0, 2, S1, "v100 d2");

    // 5. reset mid-conversion
    @(negedge clk);
    value8  = 8'd150;
    sample8 = 1'b1;
    @(negedge clk);
    sample8 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort busy", 64'(busy8), 64'd0);
    chk("abort an", 64'(an8), 64'h7);
    reset = 1'b0;
    dcnt  = 0;
    repeat (15) begin
      @(negedge clk);
      dcnt += int'(done8);
    end
    chk("abort no done", 64'(dcnt), 64'd0);
    check_digit(0, 0, S0, "abort d0");
    check_digit(0, 1, SB, "abort d1");
    check_digit(0, 2, SB, "abort d2");
    conv8(8'd89, "v89");
    check_digit(0, 0, S9, "v89 d0");
    check_digit(0, 1, S8, "v89 d1");
    check_digit(0, 2, SB, "v89 d2");

    // 6. 32-bit instance: 2971215073
    dig32 = '{3, 7, 0, 5, 1, 2, 1, 7, 9, 2};
    @(negedge clk);
    value32  = 32'd2971215073;
    sample32 = 1'b1;
    @(negedge clk);
    sample32 = 1'b0;
    k = 0;
    while (!done32 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("w32 latency", 64'(k), 64'd33);
    for (int d = 0; d < 10; d++) begin
      check_digit(1, d, seg_of(dig32[d]), $sformatf("w32 d%0d", d));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
